// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer with prefetch FIFO and redirect/halt handling
// Optional perf counters under IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    MEM_BYTES  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [DATA_WIDTH-1:0] insn_data,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  fetch_halted
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam int                    PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                    CNT_W   = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEM_BYTES - 4);
  localparam logic [CNT_W-1:0]      DEPTH   = CNT_W'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_next;
  logic [CNT_W-1:0]      count, count_after_pop;
  logic                  pop, push, in_range;
  logic                  unused_tgt;

  assign rom_addr     = pc_q;
  assign insn_valid   = (count != '0);
  assign fetch_halted = (state_q == HALT);
  assign unused_tgt   = ^redirect_target[1:0];

  always_comb begin
    pop             = insn_valid && insn_ready && !redirect_valid;
    in_range        = (pc_q <= LAST_PC);
    push            = (state_q == RUN) && enable && !redirect_valid && in_range
                      && ((count < DEPTH) || pop);
    rd_next         = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_after_pop = count - CNT_W'(pop);
    state_d         = state_q;
    pc_d            = pc_q;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
    end else if (state_q == RUN) begin
      // The last ROM word is pushed but the PC parks on it; an out-of-range PC halts without pushing.
      if (push) begin
        if (pc_q == LAST_PC) state_d = HALT;
        else                 pc_d    = pc_q + ADDR_WIDTH'(4);
      end else if (!in_range) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rom_data;
      fifo_pc[wr_ptr]   <= pc_q;
    end
  end

  // Head registers are loaded with the post-edge head so decode never sees rom_data combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      insn_data <= '0;
      insn_pc   <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      count  <= count_after_pop + CNT_W'(push);
      if (count_after_pop != '0) begin
        insn_data <= fifo_data[rd_next];
        insn_pc   <= fifo_pc[rd_next];
      end else if (push) begin
        insn_data <= rom_data;
        insn_pc   <= pc_q;
      end
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid && insn_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed and randomized self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [31:0] insn_data;
  logic [31:0] insn_pc;
  logic        fetch_halted;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  logic [31:0] rom [64];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    if (a < 32'd256) return rom[a[7:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign rom_data = rom_rd(rom_addr);

  imem_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .insn_valid      (insn_valid),
    .insn_ready      (insn_ready),
    .insn_data       (insn_data),
    .insn_pc         (insn_pc),
    .fetch_halted    (fetch_halted)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the prefetch buffer is a plain queue of {pc, word}.
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  ent_t        q[$];
  logic [31:0] m_pc = '0;
  bit          m_halt = 1'b0;
  logic [31:0] m_hpc = '0;
  logic [31:0] m_hdata = '0;
  int unsigned m_fetch = 0;
  int unsigned m_flush = 0;
  bit          m_pop;
  ent_t        e;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      m_pc = '0; m_halt = 1'b0; m_hpc = '0; m_hdata = '0; m_fetch = 0; m_flush = 0;
    end else begin
      m_pop = (q.size() > 0) && insn_ready;
      if (redirect_valid) begin
        if (q.size() > 0) m_flush++;
        q.delete();
        m_pc   = redirect_target & ~32'h3;
        m_halt = 1'b0;
      end else begin
        if (m_pop) void'(q.pop_front());
        if (!m_halt) begin
          if (m_pc > 32'd252) begin
            m_halt = 1'b1;
          end else if (enable && q.size() < 4) begin
            e.pc = m_pc; e.data = rom_rd(m_pc);
            q.push_back(e);
            m_fetch++;
            if (m_pc == 32'd252) m_halt = 1'b1;
            else                 m_pc = m_pc + 32'd4;
          end
        end
      end
      if (q.size() > 0) begin
        m_hpc = q[0].pc; m_hdata = q[0].data;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("insn_valid", {31'd0, insn_valid}, {31'd0, q.size() > 0});
    chk("insn_pc", insn_pc, m_hpc);
    chk("insn_data", insn_data, m_hdata);
    chk("rom_addr", rom_addr, m_pc);
    chk("fetch_halted", {31'd0, fetch_halted}, {31'd0, m_halt});
`ifdef IMEM_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_flush", perf_flush_cnt, m_flush);
`endif
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp5 [5];
    exp5 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 64; i++) rom[i] = $urandom;

    // Streaming from reset
    enable = 1'b1; insn_ready = 1'b1;
    do_reset();
    chk("rst_valid", {31'd0, insn_valid}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_pc", insn_pc, 32'(4 * i));
      chk("stream_data", insn_data, rom[i]);
      chk("stream_halt", {31'd0, fetch_halted}, 32'd0);
    end

    // Back-pressure fills the FIFO, then drains in order
    insn_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    chk("full_rom_addr", rom_addr, 32'h10);
    chk("full_insn_pc", insn_pc, 32'h0);
    insn_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_pc", insn_pc, exp5[i]);
      chk("drain_valid", {31'd0, insn_valid}, 32'd1);
      @(negedge clk);
    end

    // Redirect with three entries buffered
    insn_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    chk("pre_redir_addr", rom_addr, 32'hC);
    redirect_valid = 1'b1; redirect_target = 32'h42;
    @(negedge clk);
    chk("redir_valid", {31'd0, insn_valid}, 32'd0);
    chk("redir_addr", rom_addr, 32'h40);
    redirect_valid = 1'b0; insn_ready = 1'b1;
    @(negedge clk);
    chk("redir_first_valid", {31'd0, insn_valid}, 32'd1);
    chk("redir_first_pc", insn_pc, 32'h40);

    // Run to end of ROM, then restart from 0
    do_reset();
    repeat (70) @(negedge clk);
    chk("end_halted", {31'd0, fetch_halted}, 32'd1);
    chk("end_rom_addr", rom_addr, 32'hFC);
    chk("end_last_pc", insn_pc, 32'hFC);
    redirect_valid = 1'b1; redirect_target = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("restart_halted", {31'd0, fetch_halted}, 32'd0);
    chk("restart_addr", rom_addr, 32'h0);
    @(negedge clk);
    chk("restart_pc", insn_pc, 32'h0);
    chk("restart_valid", {31'd0, insn_valid}, 32'd1);

    // Asynchronous reset between edges with a full FIFO
    insn_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("prefull_valid", {31'd0, insn_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", {31'd0, insn_valid}, 32'd0);
    chk("async_rom_addr", rom_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

`ifdef IMEM_FETCH_PERF_EN
    enable = 1'b1; insn_ready = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    insn_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 32'h0;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b0; enable = 1'b0;
    chk("perf_fetch_lit", perf_fetch_cnt, 32'd5);
    chk("perf_flush_lit", perf_flush_cnt, 32'd1);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable          = ($urandom_range(0, 9) < 8);
      insn_ready      = ($urandom_range(0, 9) < 6);
      redirect_valid  = ($urandom_range(0, 99) < 4);
      redirect_target = $urandom_range(0, 300);
    end
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
